ped_req_cond: RTL

Pedestrian push-button conditioner sitting directly upstream of the traffic-light controller `tlc`. Synchronises and debounces the raw asynchronous button, latches one crossing request, and issues a single-cycle `ped_req` pulse to `tlc`. It holds a "WAIT" indicator lamp until `tlc` raises `ped_walk`, then enforces a cooldown before accepting the next request.

---
 rtl/ped_pkg.sv | 19 +
 rtl/ped_debounce.sv | 59 +++++
 rtl/ped_req_cond.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ped_pkg.sv
// ped_pkg: shared types and default parameter values for the pedestrian
// request conditioner (ped_req_cond and its ped_debounce front end).
//   ped_state_t          - request FSM states
//   PED_*_DEF            - default values for the block parameters
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        WALK     = 2'd2,
        COOLDOWN = 2'd3
    } ped_state_t;

    localparam int unsigned PED_DEBOUNCE_CYC_DEF = 32'd4;
    localparam int unsigned PED_COOLDOWN_CYC_DEF = 32'd16;
    localparam int unsigned PED_RETRY_CYC_DEF    = 32'd32;
    localparam int unsigned PED_CNT_W_DEF        = 32'd8;

endpackage : ped_pkg

// File: rtl/ped_debounce.sv
// ped_debounce: two-flop synchroniser plus counting debouncer for the raw
// pedestrian button.
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   btn_raw in   raw asynchronous, bouncy button (active high)
//   press   out  one-cycle strobe, valid on the edge where the debounced
//                level rises 0->1 (combinational from registers so the FSM
//                can act on that very edge)
module ped_debounce
    import ped_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = PED_DEBOUNCE_CYC_DEF,
    parameter int unsigned CNT_W        = PED_CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    // Count value from which the next disagreeing cycle flips the level.
    localparam logic [CNT_W-1:0] FLIP_AT = CNT_W'(DEBOUNCE_CYC - 32'd1);

    logic             sync1_r;
    logic             sync2_r;
    logic             db_r;
    logic [CNT_W-1:0] cnt_r;
    logic             flip_s;

    // Level flips on the edge where the disagreement count would reach DEBOUNCE_CYC.
    always_comb begin
        flip_s = (sync2_r != db_r) && (cnt_r >= FLIP_AT);
        press  = flip_s && !db_r;
    end

    // Synchroniser, debounce counter and debounced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            db_r    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            if (sync2_r == db_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (flip_s) begin
                cnt_r <= {CNT_W{1'b0}};
                db_r  <= ~db_r;
            end else if (cnt_r != {CNT_W{1'b1}}) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule : ped_debounce

// File: rtl/ped_req_cond.sv
// ped_req_cond: pedestrian push-button conditioner in front of the traffic
// light controller. Debounces the button, latches one crossing request,
// pulses ped_req once, lights the WAIT lamp until the walk phase, then
// holds off new requests for a cooldown period.
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   btn_raw   in   raw asynchronous button
//   ped_walk  in   walk phase indicator from the controller
//   ped_req   out  registered single-cycle request pulse
//   wait_lamp out  registered, high while a request is pending
//   busy      out  registered, high whenever the FSM is not IDLE
// Build option: define PED_RETRY_EN to re-pulse ped_req every RETRY_CYC
// cycles while a request stays pending (recovers a request the controller
// dropped). Undefined: one pulse per accepted press.
module ped_req_cond
    import ped_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = PED_DEBOUNCE_CYC_DEF,
    parameter int unsigned COOLDOWN_CYC = PED_COOLDOWN_CYC_DEF,
    parameter int unsigned RETRY_CYC    = PED_RETRY_CYC_DEF,
    parameter int unsigned CNT_W        = PED_CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic ped_walk,
    output logic ped_req,
    output logic wait_lamp,
    output logic busy
);

    localparam longint unsigned CNT_MAX   = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYC);

    // Reject parameter sets the counters cannot represent.
    if ((DEBOUNCE_CYC < 32'd1) || (RETRY_CYC < 32'd1) ||
        (CNT_W < 32'd1) || (CNT_W > 32'd32) ||
        (64'(DEBOUNCE_CYC) > CNT_MAX) || (64'(COOLDOWN_CYC) > CNT_MAX) ||
        (64'(RETRY_CYC) > CNT_MAX)) begin : g_param_err
        $error("ped_req_cond: illegal parameter combination");
    end

    ped_state_t       state_r;
    ped_state_t       state_next_s;
    logic             press_s;
    logic             req_next_s;
    logic             ped_req_r;
    logic             wait_lamp_r;
    logic             busy_r;
    logic [CNT_W-1:0] cool_cnt_r;
    logic [CNT_W-1:0] cool_cnt_next_s;
`ifdef PED_RETRY_EN
    // Counter value in the PENDING cycle just before a re-pulse is due.
    localparam logic [CNT_W-1:0] RETRY_AT = CNT_W'(RETRY_CYC - 32'd1);
    logic [CNT_W-1:0] retry_cnt_r;
    logic [CNT_W-1:0] retry_cnt_next_s;
`endif

    ped_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .press   (press_s)
    );

    // Next-state, request pulse and counter updates.
    always_comb begin
        state_next_s    = state_r;
        req_next_s      = 1'b0;
        cool_cnt_next_s = cool_cnt_r;
`ifdef PED_RETRY_EN
        retry_cnt_next_s = retry_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                // Walk already running wins over a coincident press.
                if (ped_walk) begin
                    state_next_s = WALK;
                end else if (press_s) begin
                    state_next_s = PENDING;
                    req_next_s   = 1'b1;
`ifdef PED_RETRY_EN
                    retry_cnt_next_s = {CNT_W{1'b0}};
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            PENDING: begin
                if (ped_walk) begin
                    state_next_s = WALK;
`ifdef PED_RETRY_EN
                end else if ((retry_cnt_r >= RETRY_AT) && !ped_req_r) begin
                    // The !ped_req_r term keeps pulses apart when RETRY_CYC is 1.
                    req_next_s       = 1'b1;
                    retry_cnt_next_s = {CNT_W{1'b0}};
                end else if (retry_cnt_r != {CNT_W{1'b1}}) begin
                    retry_cnt_next_s = retry_cnt_r + CNT_W'(1);
`endif
                end else begin
                    state_next_s = PENDING;
                end
            end
            WALK: begin
                if (!ped_walk) begin
                    if (COOLDOWN_CYC == 32'd0) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s    = COOLDOWN;
                        cool_cnt_next_s = COOL_LOAD;
                    end
                end else begin
                    state_next_s = WALK;
                end
            end
            COOLDOWN: begin
                if (ped_walk) begin
                    state_next_s    = WALK;
                    cool_cnt_next_s = {CNT_W{1'b0}};
                end else if (cool_cnt_r <= CNT_W'(1)) begin
                    // Count reaches zero on this edge: back to IDLE.
                    state_next_s    = IDLE;
                    cool_cnt_next_s = {CNT_W{1'b0}};
                end else begin
                    cool_cnt_next_s = cool_cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_next_s    = IDLE;
                cool_cnt_next_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ped_req_r   <= 1'b0;
            wait_lamp_r <= 1'b0;
            busy_r      <= 1'b0;
            cool_cnt_r  <= {CNT_W{1'b0}};
`ifdef PED_RETRY_EN
            retry_cnt_r <= {CNT_W{1'b0}};
`endif
        end else begin
            state_r     <= state_next_s;
            ped_req_r   <= req_next_s;
            wait_lamp_r <= (state_next_s == PENDING);
            busy_r      <= (state_next_s != IDLE);
            cool_cnt_r  <= cool_cnt_next_s;
`ifdef PED_RETRY_EN
            retry_cnt_r <= retry_cnt_next_s;
`endif
        end
    end

    assign ped_req   = ped_req_r;
    assign wait_lamp = wait_lamp_r;
    assign busy      = busy_r;

endmodule : ped_req_cond
